window_gen_3x3: RTL and testbench

Streaming 3x3 neighbourhood generator that feeds the per-pixel video filters (averager, edge, sharpen). It accepts one RGB444 pixel per clock in raster order and emits one packed 108-bit window per pixel in the exact layout the filters consume. Pixels outside the frame are zero-padded. It sits between the frame-buffer reader and the filter stage, and uses two internal line buffers.

---
 rtl/window_gen_3x3_if.sv | 22 ++
 rtl/window_gen_3x3.sv | 150 +++++++++++++++
 tb/tb_window_gen_3x3.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out stream bundle for window_gen_3x3.
// The slave side is the window generator; the master side is the source/sink around it.
interface window_gen_3x3_if;
  logic [11:0]  pix_in;
  logic         pix_valid;
  logic         sof;
  logic         in_ready;
  logic [107:0] color_data;
  logic         win_valid;
  logic         out_sof;
  logic         out_eof;

  modport master (
    output pix_in, pix_valid, sof,
    input  in_ready, color_data, win_valid, out_sof, out_eof
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output in_ready, color_data, win_valid, out_sof, out_eof
  );
endinterface

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator: raster RGB444 pixels in, one zero-padded
// 108-bit window per pixel out, using two line buffers and a 3x3 tap array.
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              reset,
  window_gen_3x3_if.slave   bus
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t             state_reg;
  logic [XW-1:0]      in_x_reg, cx_reg;
  logic [YW-1:0]      in_y_reg, cy_reg;
  logic [2:0][11:0]   dn_reg, md_reg, up_reg;
  logic [107:0]       color_data_reg;
  logic               win_valid_reg, out_sof_reg, out_eof_reg;

  logic [11:0]        lb_a [IMG_WIDTH];
  logic [11:0]        lb_b [IMG_WIDTH];
  logic [11:0]        rd_a_reg, rd_b_reg;

  logic               in_ready, accept, restart, take, flush_step, step, emit;
  logic [11:0]        step_pix;
  logic [XW-1:0]      ptr_next, wr_addr, rd_addr;
  logic [2:0][11:0]   dn_next, md_next, up_next;
  logic [11:0]        tap [9];
  logic [8:0]         keep;
  logic [107:0]       color_next;
  logic               col_l, col_r, row_u, row_d;

  assign in_ready   = (state_reg != FLUSH);
  assign accept     = bus.pix_valid & in_ready;
  assign restart    = accept & bus.sof;
  assign take       = accept & ~bus.sof & ((state_reg == FILL) | (state_reg == RUN));
  assign flush_step = (state_reg == FLUSH);
  assign step       = restart | take | flush_step;
  assign step_pix   = flush_step ? 12'd0 : bus.pix_in;
  assign emit       = flush_step
                    | (take & ((state_reg == RUN) | ((in_x_reg == X_ONE) & (in_y_reg == Y_ONE))));

  assign ptr_next = (in_x_reg == X_LAST) ? '0 : in_x_reg + 1'b1;
  assign wr_addr  = restart ? '0 : in_x_reg;
  assign rd_addr  = restart ? X_ONE : ptr_next;

  // Tap [0] is the newest pixel of each row: down row = k..k-2, middle = k-W.., up = k-2W..
  assign dn_next = {dn_reg[1], dn_reg[0], step_pix};
  assign md_next = {md_reg[1], md_reg[0], rd_a_reg};
  assign up_next = {up_reg[1], up_reg[0], rd_b_reg};

  assign col_l = (cx_reg != '0);
  assign col_r = (cx_reg != X_LAST);
  assign row_u = (cy_reg != '0);
  assign row_d = (cy_reg != Y_LAST);

  always_comb begin
    tap[0] = md_next[1];  keep[0] = 1'b1;
    tap[1] = md_next[2];  keep[1] = col_l;
    tap[2] = md_next[0];  keep[2] = col_r;
    tap[3] = up_next[1];  keep[3] = row_u;
    tap[4] = dn_next[1];  keep[4] = row_d;
    tap[5] = up_next[2];  keep[5] = row_u & col_l;
    tap[6] = up_next[0];  keep[6] = row_u & col_r;
    tap[7] = dn_next[2];  keep[7] = row_d & col_l;
    tap[8] = dn_next[0];  keep[8] = row_d & col_r;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_field
      assign color_next[107-12*gi -: 12] = keep[gi] ? tap[gi] : 12'd0;
    end
  endgenerate

  // Line buffers carry no reset; stale entries only ever land in masked positions.
  always_ff @(posedge clk) begin
    if (step) begin
      lb_a[wr_addr] <= step_pix;
      lb_b[wr_addr] <= rd_a_reg;
      rd_a_reg      <= lb_a[rd_addr];
      rd_b_reg      <= lb_b[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      in_x_reg       <= '0;
      in_y_reg       <= '0;
      cx_reg         <= '0;
      cy_reg         <= '0;
      dn_reg         <= '0;
      md_reg         <= '0;
      up_reg         <= '0;
      color_data_reg <= '0;
      win_valid_reg  <= 1'b0;
      out_sof_reg    <= 1'b0;
      out_eof_reg    <= 1'b0;
    end else begin
      win_valid_reg <= emit;
      out_sof_reg   <= emit & (cx_reg == '0) & (cy_reg == '0);
      out_eof_reg   <= emit & (cx_reg == X_LAST) & (cy_reg == Y_LAST);
      if (emit) begin
        color_data_reg <= color_next;
        cx_reg <= (cx_reg == X_LAST) ? '0 : cx_reg + 1'b1;
        if (cx_reg == X_LAST)
          cy_reg <= (cy_reg == Y_LAST) ? '0 : cy_reg + 1'b1;
      end

      if (restart) begin
        state_reg <= FILL;
        in_x_reg  <= X_ONE;
        in_y_reg  <= '0;
        cx_reg    <= '0;
        cy_reg    <= '0;
        dn_reg    <= {12'd0, 12'd0, bus.pix_in};
        md_reg    <= '0;
        up_reg    <= '0;
      end else if (step) begin
        dn_reg   <= dn_next;
        md_reg   <= md_next;
        up_reg   <= up_next;
        in_x_reg <= ptr_next;
        if (in_x_reg == X_LAST)
          in_y_reg <= (in_y_reg == Y_LAST) ? '0 : in_y_reg + 1'b1;

        case (state_reg)
          FILL:  if ((in_x_reg == X_ONE) && (in_y_reg == Y_ONE)) state_reg <= RUN;
          RUN:   if ((in_x_reg == X_LAST) && (in_y_reg == Y_LAST)) state_reg <= FLUSH;
          FLUSH: if ((cx_reg == X_LAST) && (cy_reg == Y_LAST)) state_reg <= IDLE;
          default: state_reg <= state_reg;
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.color_data = color_data_reg;
  assign bus.win_valid  = win_valid_reg;
  assign bus.out_sof    = out_sof_reg;
  assign bus.out_eof    = out_eof_reg;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3 (4x3 frames): a frame-array reference model
// pushes expected windows with due cycles; a negedge monitor pops and compares.
module tb_window_gen_3x3;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window_gen_3x3_if bus();

  window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [107:0] win;
    logic         sof;
    logic         eof;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  logic [107:0] cap_q[$];
  logic [107:0] ref_q[$];
  bit           capture = 0;
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;

  logic [11:0]  frame [N];
  bit           active = 0;
  int           n = 0;
  int           ready_from = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [11:0] get(input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 12'd0;
    return frame[y*W + x];
  endfunction

  function automatic logic [107:0] win_at(input int c);
    int x = c % W;
    int y = c / W;
    return {get(x, y), get(x-1, y), get(x+1, y), get(x, y-1), get(x, y+1),
            get(x-1, y-1), get(x+1, y-1), get(x-1, y+1), get(x+1, y+1)};
  endfunction

  task automatic push(input int c, input int due);
    exp_t e;
    e.win = win_at(c);
    e.sof = (c == 0);
    e.eof = (c == N - 1);
    e.due = due;
    exp_q.push_back(e);
  endtask

  // Called at the negedge before the accepting posedge.
  task automatic model_accept(input logic [11:0] p, input bit s);
    if (s) begin
      active = 1; n = 0; frame[0] = p;
      return;
    end
    if (!active) return;
    n++;
    frame[n] = p;
    if (n >= W + 1) push(n - W - 1, cyc + 1);
    if (n == N - 1) begin
      for (int c = n - W; c < N; c++) push(c, cyc + 2 + (c - (n - W)));
      active = 0;
      ready_from = cyc + W + 2;
    end
  endtask

  task automatic send(input logic [11:0] p, input bit s);
    int  tries = 0;
    bit  mready;
    forever begin
      @(negedge clk);
      bus.pix_in = p; bus.pix_valid = 1'b1; bus.sof = s;
      mready = (cyc >= ready_from);
      check("in_ready", 128'(bus.in_ready), 128'(mready));
      if (mready) begin
        model_accept(p, s);
        break;
      end
      tries++;
      if (tries > 50) begin
        check("accept_timeout", 128'(tries), 128'(0));
        break;
      end
    end
  endtask

  task automatic gap(input int k);
    repeat (k) begin
      @(negedge clk);
      bus.pix_valid = 1'b0; bus.sof = 1'b0;
      check("in_ready_idle", 128'(bus.in_ready), 128'(cyc >= ready_from));
    end
  endtask

  task automatic seq_frame(input int start, input bit gaps);
    for (int i = 0; i < N; i++) begin
      send(12'(start + i), i == 0);
      if (gaps && $urandom_range(0, 1) == 1) gap(1 + $urandom_range(0, 1));
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.win_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_window", bus.color_data, 128'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("color_data", bus.color_data, e.win);
        check("out_sof", 128'(bus.out_sof), 128'(e.sof));
        check("out_eof", 128'(bus.out_eof), 128'(e.eof));
        check("win_time", 128'(cyc), 128'(e.due));
        if (capture) cap_q.push_back(bus.color_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [107:0] c0, c5, c11;

  initial begin
    c0  = {12'd1, 12'd0, 12'd2, 12'd0, 12'd5, 12'd0, 12'd0, 12'd0, 12'd6};
    c5  = {12'd6, 12'd5, 12'd7, 12'd2, 12'd10, 12'd1, 12'd3, 12'd9, 12'd11};
    c11 = {12'd12, 12'd11, 12'd0, 12'd8, 12'd0, 12'd7, 12'd0, 12'd0, 12'd0};

    reset = 1'b1;
    bus.pix_in = '0; bus.pix_valid = 1'b0; bus.sof = 1'b0;
    #1;
    check("rst_color_data", bus.color_data, 128'(0));
    check("rst_win_valid", 128'(bus.win_valid), 128'(0));
    check("rst_out_sof", 128'(bus.out_sof), 128'(0));
    check("rst_out_eof", 128'(bus.out_eof), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Pixels without sof in IDLE are dropped.
    for (int i = 0; i < 3; i++) send(12'($urandom_range(0, 4095)), 1'b0);
    gap(2);

    // Continuous reference frame.
    capture = 1;
    seq_frame(1, 1'b0);
    gap(W + 4);
    capture = 0;
    check("frame1_count", 128'(cap_q.size()), 128'(N));
    if (cap_q.size() == N) begin
      check("frame1_c0", cap_q[0], c0);
      check("frame1_c5", cap_q[5], c5);
      check("frame1_c11", cap_q[N-1], c11);
    end
    ref_q = cap_q;
    cap_q.delete();

    // Same frame with random input gaps must give an identical window sequence.
    capture = 1;
    seq_frame(1, 1'b1);
    gap(W + 4);
    capture = 0;
    check("gapped_count", 128'(cap_q.size()), 128'(N));
    for (int i = 0; i < N && i < cap_q.size(); i++) check("gapped_vs_continuous", cap_q[i], ref_q[i]);
    cap_q.delete();

    // sof at value 8 abandons the frame without flushing; continue into a full new frame.
    for (int i = 1; i <= 7; i++) send(12'(i), i == 1);
    for (int i = 0; i < N; i++) send(12'(8 + i), i == 0);
    gap(W + 4);

    // Random-content frames with random gaps.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) begin
        send(12'($urandom_range(0, 4095)), i == 0);
        if ($urandom_range(0, 1) == 1) gap(1 + $urandom_range(0, 1));
      end
      gap(W + 3);
    end

    // Reset asserted during RUN.
    for (int i = 1; i <= 8; i++) send(12'(i), i == 1);
    @(negedge clk);
    bus.pix_valid = 1'b0; bus.sof = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_color_data", bus.color_data, 128'(0));
    check("midrst_win_valid", 128'(bus.win_valid), 128'(0));
    check("midrst_out_sof", 128'(bus.out_sof), 128'(0));
    check("midrst_out_eof", 128'(bus.out_eof), 128'(0));
    check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    exp_q.delete();
    active = 0;
    ready_from = 0;
    @(negedge clk);
    reset = 1'b0;

    capture = 1;
    seq_frame(1, 1'b0);
    gap(W + 4);
    capture = 0;
    check("postrst_count", 128'(cap_q.size()), 128'(N));
    if (cap_q.size() > 0) check("postrst_c0", cap_q[0], c0);

    gap(10);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
